// File: rtl/icb_arbiter.sv
// N-to-1 ICB command arbiter with in-order response routing through an ID FIFO.
// Define ICB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default is round-robin.
module icb_arbiter #(
  parameter int MASTER_N      = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int OUTSTANDING_N = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [MASTER_N*ADDR_WIDTH-1:0]      s_cmd_addr,
  input  logic [MASTER_N-1:0]                 s_cmd_read,
  input  logic [MASTER_N*DATA_WIDTH-1:0]      s_cmd_wdata,
  input  logic [MASTER_N*(DATA_WIDTH/8)-1:0]  s_cmd_wmask,
  input  logic [MASTER_N-1:0]                 s_cmd_valid,
  output logic [MASTER_N-1:0]                 s_cmd_ready,
  output logic [MASTER_N*DATA_WIDTH-1:0]      s_rsp_rdata,
  output logic [MASTER_N-1:0]                 s_rsp_err,
  output logic [MASTER_N-1:0]                 s_rsp_valid,
  input  logic [MASTER_N-1:0]                 s_rsp_ready,
  output logic [ADDR_WIDTH-1:0]               m_cmd_addr,
  output logic                                m_cmd_read,
  output logic [DATA_WIDTH-1:0]               m_cmd_wdata,
  output logic [DATA_WIDTH/8-1:0]             m_cmd_wmask,
  output logic                                m_cmd_valid,
  input  logic                                m_cmd_ready,
  input  logic [DATA_WIDTH-1:0]               m_rsp_rdata,
  input  logic                                m_rsp_err,
  input  logic                                m_rsp_valid,
  output logic                                m_rsp_ready
);

  localparam int IDW = $clog2(MASTER_N);
  localparam int MW  = DATA_WIDTH / 8;
  localparam int PW  = (OUTSTANDING_N > 1) ? $clog2(OUTSTANDING_N) : 1;
  localparam int CW  = $clog2(OUTSTANDING_N + 1);

  logic           lock_vld;
  logic [IDW-1:0] lock_idx;
  logic [IDW-1:0] arb_idx;
  logic [IDW-1:0] grant;
  logic           cmd_hs;
  logic           rsp_hs;

  logic [IDW-1:0] id_mem [OUTSTANDING_N];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [IDW-1:0] head;
  logic           fifo_full;
  logic           fifo_empty;

`ifdef ICB_ARB_FIXED_PRIO_EN
  always_comb begin : arb_fixed
    logic found;
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    arb_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < MASTER_N; i++) begin
      if (!found && s_cmd_valid[i]) begin
        arb_idx = IDW'(i);
        found   = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Search starts at ptr and wraps, so the master after the last winner is preferred.
  always_comb begin : arb_rr
    logic found;
    int   idx;
    arb_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < MASTER_N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= MASTER_N) idx = idx - MASTER_N;
      if (!found && s_cmd_valid[idx]) begin
        arb_idx = IDW'(idx);
        found   = 1'b1;
      end
    end
  end
`endif

  // A stalled command keeps its grant until accepted, keeping the payload stable.
  assign grant       = lock_vld ? lock_idx : arb_idx;
  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CW'(OUTSTANDING_N));
  assign m_cmd_valid = s_cmd_valid[grant] & ~fifo_full;
  assign m_cmd_addr  = s_cmd_addr[grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_cmd_read  = s_cmd_read[grant];
  assign m_cmd_wdata = s_cmd_wdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_cmd_wmask = s_cmd_wmask[grant*MW +: MW];
  assign cmd_hs      = m_cmd_valid & m_cmd_ready;
  assign s_cmd_ready = cmd_hs ? (MASTER_N'(1) << grant) : '0;

  assign head        = id_mem[rd_ptr];
  assign m_rsp_ready = ~fifo_empty & s_rsp_ready[head];
  assign rsp_hs      = m_rsp_valid & m_rsp_ready;
  assign s_rsp_valid = (m_rsp_valid & ~fifo_empty) ? (MASTER_N'(1) << head) : '0;
  assign s_rsp_rdata = {MASTER_N{m_rsp_rdata}};
  assign s_rsp_err   = {MASTER_N{m_rsp_err}};

  // NOTE: the ID storage has no reset; entries are only read between valid pointers.
  always_ff @(posedge clk) begin
    if (cmd_hs) id_mem[wr_ptr] <= grant;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_idx <= '0;
`ifndef ICB_ARB_FIXED_PRIO_EN
      ptr      <= '0;
`endif
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      lock_vld <= m_cmd_valid & ~m_cmd_ready;
      lock_idx <= grant;
`ifndef ICB_ARB_FIXED_PRIO_EN
      if (cmd_hs) ptr <= (grant == IDW'(MASTER_N - 1)) ? '0 : grant + IDW'(1);
`endif
      if (cmd_hs) wr_ptr <= (wr_ptr == PW'(OUTSTANDING_N - 1)) ? '0 : wr_ptr + PW'(1);
      if (rsp_hs) rd_ptr <= (rd_ptr == PW'(OUTSTANDING_N - 1)) ? '0 : rd_ptr + PW'(1);
      case ({cmd_hs, rsp_hs})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_icb_arbiter.sv
// Directed bench for icb_arbiter (round-robin build, MASTER_N=4, OUTSTANDING_N=4).
module tb_icb_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] s_cmd_addr;
  logic [3:0]   s_cmd_read;
  logic [127:0] s_cmd_wdata;
  logic [15:0]  s_cmd_wmask;
  logic [3:0]   s_cmd_valid;
  logic [3:0]   s_cmd_ready;
  logic [127:0] s_rsp_rdata;
  logic [3:0]   s_rsp_err;
  logic [3:0]   s_rsp_valid;
  logic [3:0]   s_rsp_ready;
  logic [31:0]  m_cmd_addr;
  logic         m_cmd_read;
  logic [31:0]  m_cmd_wdata;
  logic [3:0]   m_cmd_wmask;
  logic         m_cmd_valid;
  logic         m_cmd_ready;
  logic [31:0]  m_rsp_rdata;
  logic         m_rsp_err;
  logic         m_rsp_valid;
  logic         m_rsp_ready;

  int vectors = 0;
  int errs    = 0;

  logic [3:0] a_grant [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
  logic [3:0] a_rsp   [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] c_grant [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

  icb_arbiter #(
    .MASTER_N(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .OUTSTANDING_N(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_cmd_addr(s_cmd_addr), .s_cmd_read(s_cmd_read), .s_cmd_wdata(s_cmd_wdata),
    .s_cmd_wmask(s_cmd_wmask), .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
    .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err), .s_rsp_valid(s_rsp_valid),
    .s_rsp_ready(s_rsp_ready),
    .m_cmd_addr(m_cmd_addr), .m_cmd_read(m_cmd_read), .m_cmd_wdata(m_cmd_wdata),
    .m_cmd_wmask(m_cmd_wmask), .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
    .m_rsp_rdata(m_rsp_rdata), .m_rsp_err(m_rsp_err), .m_rsp_valid(m_rsp_valid),
    .m_rsp_ready(m_rsp_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    s_cmd_valid = '0;
    s_rsp_ready = '0;
    m_cmd_ready = 1'b0;
    m_rsp_valid = 1'b0;
    m_rsp_err   = 1'b0;
    m_rsp_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      s_cmd_addr[i*32 +: 32]  = 32'hA000_0000 + 32'(i);
      s_cmd_wdata[i*32 +: 32] = 32'hD000_0000 + 32'(i);
      s_cmd_wmask[i*4 +: 4]   = 4'(i + 1);
      s_cmd_read[i]           = i[0];
    end
    repeat (2) nxt();
    rst_n = 1'b1;
    #1;
    check("rst_m_cmd_valid", m_cmd_valid, 1'b0);
    check("rst_s_cmd_ready", s_cmd_ready, 4'b0000);
    check("rst_s_rsp_valid", s_rsp_valid, 4'b0000);
    check("rst_m_rsp_ready", m_rsp_ready, 1'b0);
    nxt();

    // All masters request, responses return the cycle after each command.
    m_cmd_ready = 1'b1;
    m_rsp_valid = 1'b1;
    m_rsp_rdata = 32'hCAFE_0001;
    s_rsp_ready = 4'b1111;
    s_cmd_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_grant%0d", k), s_cmd_ready, a_grant[k]);
      check($sformatf("rr_rsp%0d", k), s_rsp_valid, a_rsp[k]);
      if (k == 0) begin
        check("rr_addr0", m_cmd_addr, 32'hA000_0000);
        check("rr_mrdy0", m_rsp_ready, 1'b0);
      end
      if (k == 1) check("rr_rdata_bcast", s_rsp_rdata, {4{32'hCAFE_0001}});
      nxt();
    end
    s_cmd_valid = 4'b0000;
    #1;
    check("rr_tail_rsp", s_rsp_valid, 4'b0010);
    check("rr_tail_cmdv", m_cmd_valid, 1'b0);
    nxt();
    #1;
    check("empty_stray_rsp", s_rsp_valid, 4'b0000);
    check("empty_stray_rdy", m_rsp_ready, 1'b0);
    m_rsp_valid = 1'b0;

    // Master 3 alone moves ptr to 0, then grant lock on master 2.
    s_cmd_valid = 4'b1000;
    #1;
    check("solo3_grant", s_cmd_ready, 4'b1000);
    nxt();
    s_cmd_valid = 4'b0100;
    m_cmd_ready = 1'b0;
    #1;
    check("lock_c0_valid", m_cmd_valid, 1'b1);
    check("lock_c0_ready", s_cmd_ready, 4'b0000);
    check("lock_c0_addr", m_cmd_addr, 32'hA000_0002);
    nxt();
    s_cmd_valid = 4'b0101;
    #1;
    check("lock_c1_ready", s_cmd_ready, 4'b0000);
    check("lock_c1_addr", m_cmd_addr, 32'hA000_0002);
    check("lock_c1_wdata", m_cmd_wdata, 32'hD000_0002);
    nxt();
    #1;
    check("lock_c2_addr", m_cmd_addr, 32'hA000_0002);
    nxt();
    m_cmd_ready = 1'b1;
    #1;
    check("lock_accept2", s_cmd_ready, 4'b0100);
    check("lock_wmask2", m_cmd_wmask, 4'h3);
    check("lock_read2", m_cmd_read, 1'b0);
    nxt();
    s_cmd_valid = 4'b0001;
    #1;
    check("lock_then0", s_cmd_ready, 4'b0001);
    check("lock_then0_addr", m_cmd_addr, 32'hA000_0000);
    nxt();
    s_cmd_valid = 4'b0000;

    // Drain IDs 3,2,0 in issue order.
    m_rsp_valid = 1'b1;
    m_rsp_err   = 1'b1;
    #1;
    check("drain_rsp3", s_rsp_valid, 4'b1000);
    check("drain_err_bcast", s_rsp_err, 4'b1111);
    nxt();
    m_rsp_err = 1'b0;
    #1;
    check("drain_rsp2", s_rsp_valid, 4'b0100);
    nxt();
    #1;
    check("drain_rsp0", s_rsp_valid, 4'b0001);
    nxt();
    m_rsp_valid = 1'b0;

    // Fill the ID FIFO: four accepted, fifth held until one pop has completed.
    s_cmd_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("fill_grant%0d", k), s_cmd_ready, c_grant[k]);
      nxt();
    end
    #1;
    check("full_cmd_valid", m_cmd_valid, 1'b0);
    check("full_cmd_ready", s_cmd_ready, 4'b0000);
    nxt();
    m_rsp_valid = 1'b1;
    #1;
    check("full_pop_rsp", s_rsp_valid, 4'b0010);
    check("full_pop_mrdy", m_rsp_ready, 1'b1);
    check("full_pop_no_push", m_cmd_valid, 1'b0);
    nxt();
    m_rsp_valid = 1'b0;
    #1;
    check("after_pop_grant", s_cmd_ready, 4'b0010);
    nxt();
    s_cmd_valid = 4'b0000;

    // Pop 2,3,0 so head is 1, then back-pressure master 1.
    m_rsp_valid = 1'b1;
    #1;
    check("bp_pre_rsp2", s_rsp_valid, 4'b0100);
    nxt();
    #1;
    check("bp_pre_rsp3", s_rsp_valid, 4'b1000);
    nxt();
    #1;
    check("bp_pre_rsp0", s_rsp_valid, 4'b0001);
    nxt();
    s_rsp_ready = 4'b1101;
    #1;
    check("bp_c0_mrdy", m_rsp_ready, 1'b0);
    check("bp_c0_rsp", s_rsp_valid, 4'b0010);
    nxt();
    #1;
    check("bp_c1_mrdy", m_rsp_ready, 1'b0);
    check("bp_c1_rsp", s_rsp_valid, 4'b0010);
    nxt();
    s_rsp_ready = 4'b1111;
    #1;
    check("bp_pop_mrdy", m_rsp_ready, 1'b1);
    check("bp_pop_rsp", s_rsp_valid, 4'b0010);
    nxt();
    #1;
    check("bp_after_rsp", s_rsp_valid, 4'b0000);
    check("bp_after_mrdy", m_rsp_ready, 1'b0);
    m_rsp_valid = 1'b0;

    // Three outstanding, then a one-cycle reset discards them and clears ptr.
    s_cmd_valid = 4'b1111;
    #1;
    check("pre_rst_g2", s_cmd_ready, 4'b0100);
    nxt();
    #1;
    check("pre_rst_g3", s_cmd_ready, 4'b1000);
    nxt();
    #1;
    check("pre_rst_g0", s_cmd_ready, 4'b0001);
    nxt();
    s_cmd_valid = 4'b0000;
    rst_n       = 1'b0;
    nxt();
    rst_n       = 1'b1;
    m_rsp_valid = 1'b1;
    #1;
    check("mid_rst_rsp", s_rsp_valid, 4'b0000);
    check("mid_rst_mrdy", m_rsp_ready, 1'b0);
    check("mid_rst_cmdv", m_cmd_valid, 1'b0);
    s_cmd_valid = 4'b1111;
    #1;
    check("mid_rst_grant0", s_cmd_ready, 4'b0001);
    nxt();
    s_cmd_valid = 4'b0000;
    #1;
    check("mid_rst_head0", s_rsp_valid, 4'b0001);
    nxt();
    m_rsp_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/icb_arbiter.md
ICB_ARBITER -- requirements
Module: icb_arbiter

Interface
REQ-001 SHALL have parameter MASTER_N, default 4, number of upstream ICB masters (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, command address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-004 SHALL have parameter OUTSTANDING_N, default 4, depth of response-routing ID FIFO (1..16).
REQ-005 SHALL have port clk  input  1  block clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-007 SHALL have ports s_cmd_addr/s_cmd_read/s_cmd_wdata/s_cmd_wmask/s_cmd_valid  input  MASTER_N x (ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8/1), packed, master i at slice i  upstream commands.
REQ-008 SHALL have port s_cmd_ready  output  MASTER_N  per-master command accept.
REQ-009 SHALL have ports s_rsp_rdata/s_rsp_err/s_rsp_valid  output  MASTER_N x (DATA_WIDTH/1/1)  per-master responses.
REQ-010 SHALL have port s_rsp_ready  input  MASTER_N  per-master response accept.
REQ-011 SHALL have ports m_cmd_addr/m_cmd_read/m_cmd_wdata/m_cmd_wmask/m_cmd_valid  output  ADDR_WIDTH/1/DATA_WIDTH/DATA_WIDTH/8/1  downstream command.
REQ-012 SHALL have ports m_cmd_ready, m_rsp_rdata, m_rsp_err, m_rsp_valid  input  1/DATA_WIDTH/1/1; m_rsp_ready  output  1.

Function
REQ-013 Handshake on any channel SHALL occur in a cycle where valid and ready are both 1.
REQ-014 Arbitration SHALL be combinational over s_cmd_valid; winner's payload SHALL drive m_cmd_* same cycle; m_cmd_valid = any request AND ID FIFO not full.
REQ-015 Round-robin: search SHALL start at priority pointer ptr; after each m_cmd handshake ptr <= (granted+1) mod MASTER_N; ptr otherwise unchanged.
REQ-016 Grant lock: when m_cmd_valid=1 and m_cmd_ready=0, grant SHALL be registered and held until the handshake, regardless of other requests.
REQ-017 s_cmd_ready[i] SHALL equal m_cmd_ready AND grant==i AND m_cmd_valid; all other bits 0.
REQ-018 On each m_cmd handshake the granted index SHALL be pushed into the ID FIFO.
REQ-019 ID FIFO full: m_cmd_valid SHALL be 0, no push, even if a pop occurs in the same cycle.
REQ-020 Response routing: head index h SHALL select s_rsp_valid[h]=m_rsp_valid, s_rsp_rdata/err broadcast to all, m_rsp_ready=s_rsp_ready[h]; other s_rsp_valid bits 0.
REQ-021 ID FIFO empty: m_rsp_ready SHALL be 0, all s_rsp_valid 0 (stray downstream response stalls).
REQ-022 On each m_rsp handshake the FIFO head SHALL pop; simultaneous push and pop when not full SHALL keep count unchanged.
REQ-023 Responses SHALL be returned in command-issue order; command-to-response latency through block SHALL be 0 cycles combinational.

Reset
REQ-024 While rst_n=0 at clk edge: ptr=0, grant lock cleared, FIFO pointers and count = 0.
REQ-025 After reset all valid and ready outputs SHALL be 0 until requests/responses appear; in-flight transactions SHALL be discarded on mid-operation reset.

Configuration
REQ-026 Macro ICB_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, ptr unused; grant lock (REQ-016) still applies.
REQ-027 Macro ICB_ARB_FIXED_PRIO_EN undefined: round-robin per REQ-015.

Verification (MASTER_N=4, OUTSTANDING_N=4, m_cmd_ready=1 and m_rsp immediate unless stated)
REQ-028 All four masters request continuously after reset -> grants 0,1,2,3,0 on consecutive handshakes; responses delivered to 0,1,2,3,0.
REQ-029 Master 2 requests with m_cmd_ready=0 for 3 cycles while master 0 raises request in cycle 1 -> grant stays 2, payload stable, master 2 accepted cycle 4, then master 0.
REQ-030 m_rsp_valid=0 while masters issue 5 commands -> 4 accepted, m_cmd_valid=0 on 5th; one response returns -> 5th accepted next cycle, not same cycle.
REQ-031 Head=1 with s_rsp_ready[1]=0 for 2 cycles -> m_rsp_ready=0, s_rsp_valid=4'b0010 held, pop on cycle s_rsp_ready[1]=1.
REQ-032 rst_n=0 for 1 cycle with 3 outstanding -> FIFO empty, ptr=0, next grant to lowest requester.
REQ-033 With ICB_ARB_FIXED_PRIO_EN, masters 1 and 3 request continuously -> master 1 granted every cycle, master 3 starves.
